// File: rtl/ahb_lite_data_master_pkg.sv
// rtl/ahb_lite_data_master_pkg.sv - AHB-Lite encodings shared by all bus masters
package ahb_lite_data_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  // Size 3 is never legal; halves need even, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return |off;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// rtl/ahb_lane_align.sv - write lane replication and read lane extract/zero-extend
module ahb_lane_align
  import ahb_lite_data_master_pkg::*;
(
  input  logic [1:0]  i_wsize,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_hwdata,
  input  logic [1:0]  i_rsize,
  input  logic [1:0]  i_roff,
  input  logic [31:0] i_hrdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  always_comb begin
    case (i_wsize)
      SIZE_BYTE: o_hwdata = {4{i_wdata[7:0]}};
      SIZE_HALF: o_hwdata = {2{i_wdata[15:0]}};
      default:   o_hwdata = i_wdata;
    endcase
  end

  assign w_shifted = i_hrdata >> {i_roff, 3'b000};

  always_comb begin
    case (i_rsize)
      SIZE_BYTE: o_rdata = {24'h0, w_shifted[7:0]};
      SIZE_HALF: o_rdata = {16'h0, w_shifted[15:0]};
      default:   o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/ahb_lite_data_master.sv
// rtl/ahb_lite_data_master.sv - pipelined AHB-Lite initiator for the load/store unit
module ahb_lite_data_master
  import ahb_lite_data_master_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WRITE,
  input  logic [1:0]    REQ_SIZE,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [31:0]   REQ_WDATA,
  output logic          RSP_VALID,
  output logic [31:0]   RSP_RDATA,
  output logic          RSP_ERR,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA
);

  logic          r_ap_valid;
  logic          r_ap_write;
  logic          r_ap_mis;
  logic [1:0]    r_ap_size;
  logic [AW-1:0] r_ap_addr;
  logic [31:0]   r_ap_wdata;

  logic          r_dp_valid;
  logic          r_dp_write;
  logic          r_dp_mis;
  logic [1:0]    r_dp_size;
  logic [1:0]    r_dp_off;
  logic [31:0]   r_dp_wdata;

  logic          r_err1;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;

  logic          w_accept;
  logic          w_ap_done;
  logic          w_dp_done;
  logic          w_err_next;
  logic          w_bus_err;
  logic [31:0]   w_hwdata;
  logic [31:0]   w_rdata;

  assign REQ_READY  = !r_ap_valid || (HREADY && !r_err1);
  assign w_accept   = REQ_VALID && REQ_READY;
  assign w_ap_done  = r_ap_valid && HREADY && !r_err1;
  assign w_dp_done  = r_dp_valid && HREADY;
  assign w_bus_err  = (HRESP == HRESP_ERROR) && !r_dp_mis;
  // First cycle of the two-cycle ERROR response; misaligned entries never reach a slave.
  assign w_err_next = r_dp_valid && w_bus_err && !HREADY;

  // Misaligned entries ride the pipeline as IDLE slots so responses stay in order.
  assign HTRANS = (r_ap_valid && !r_ap_mis && !r_err1) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = r_ap_addr;
  assign HWRITE = r_ap_write;
  assign HSIZE  = {1'b0, r_ap_size};
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA;
  assign HWDATA = w_hwdata;

  assign RSP_VALID = r_rsp_valid;
  assign RSP_ERR   = r_rsp_err;
  assign RSP_RDATA = r_rsp_rdata;

  ahb_lane_align u_lane_align (
    .i_wsize  (r_dp_size),
    .i_wdata  (r_dp_wdata),
    .o_hwdata (w_hwdata),
    .i_rsize  (r_dp_size),
    .i_roff   (r_dp_off),
    .i_hrdata (HRDATA),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_mis   <= 1'b0;
      r_ap_size  <= 2'd0;
      r_ap_addr  <= '0;
      r_ap_wdata <= 32'h0;
    end else if (w_accept) begin
      r_ap_valid <= 1'b1;
      r_ap_write <= REQ_WRITE;
      r_ap_mis   <= is_misaligned(REQ_SIZE, REQ_ADDR[1:0]);
      r_ap_size  <= REQ_SIZE;
      r_ap_addr  <= REQ_ADDR;
      r_ap_wdata <= REQ_WDATA;
    end else if (w_ap_done) begin
      r_ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_mis   <= 1'b0;
      r_dp_size  <= 2'd0;
      r_dp_off   <= 2'd0;
      r_dp_wdata <= 32'h0;
    end else if (w_ap_done) begin
      r_dp_valid <= 1'b1;
      r_dp_write <= r_ap_write;
      r_dp_mis   <= r_ap_mis;
      r_dp_size  <= r_ap_size;
      r_dp_off   <= r_ap_addr[1:0];
      r_dp_wdata <= r_ap_wdata;
    end else if (w_dp_done) begin
      r_dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err1      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= RSP_OKAY;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_err1      <= w_err_next;
      r_rsp_valid <= w_dp_done;
      r_rsp_err   <= (w_dp_done && (r_dp_mis || w_bus_err)) ? RSP_ERROR : RSP_OKAY;
      r_rsp_rdata <= (w_dp_done && !r_dp_write && !r_dp_mis && !w_bus_err) ? w_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_data_master.sv
// tb/tb_ahb_lite_data_master.sv - directed scoreboard bench for ahb_lite_data_master
module tb_ahb_lite_data_master;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t nxt_exp;
  exp_t mon_e;

  always #5 HCLK = ~HCLK;

  ahb_lite_data_master #(.AW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_align(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    case (sz)
      2'd0:    return {24'h0, b[off]};
      2'd1:    return {16'h0, b[off + 2'd1], b[off]};
      default: return d;
    endcase
  endfunction

  function automatic exp_t exp_of(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] hrd, input logic berr);
    exp_t r;
    r.err   = berr || bad_align(sz, a[1:0]);
    r.rdata = (r.err || w) ? 32'h0 : model_rd(sz, a[1:0], hrd);
    return r;
  endfunction

  task automatic step(input logic rv, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic hr, input logic hresp, input logic [31:0] hrd,
                      input exp_t ex);
    @(posedge HCLK);
    #1;
    REQ_VALID = rv; REQ_WRITE = w; REQ_SIZE = sz; REQ_ADDR = a; REQ_WDATA = wd;
    HREADY = hr; HRESP = hresp; HRDATA = hrd; nxt_exp = ex;
    #1;
  endtask

  task automatic idle(input logic hr, input logic hresp, input logic [31:0] hrd);
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, hr, hresp, hrd, '0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1, 1'b0, 32'h0);
    chk(tag, 32'(sb.size()), 32'h0);
  endtask

  // Scoreboard: push on handshake, pop and compare on each response pulse.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (REQ_VALID && REQ_READY) sb.push_back(nxt_exp);
      if (RSP_VALID) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL rsp_unexpected: observed response with rdata=%h, expected none", RSP_RDATA);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("rsp_err", 32'(RSP_ERR), 32'(mon_e.err));
          chk("rsp_rdata", RSP_RDATA, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    HRESET = 1'b1;
    REQ_VALID = 0; REQ_WRITE = 0; REQ_SIZE = 0; REQ_ADDR = 0; REQ_WDATA = 0;
    HREADY = 1; HRESP = 0; HRDATA = 0; nxt_exp = '0;
    @(posedge HCLK);
    #2;
    chk("rst_ready", 32'(REQ_READY), 1);
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hsize", 32'(HSIZE), 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_rdata", RSP_RDATA, 0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Word store, zero wait states
    step(1, 1, 2, 32'h2000_0010, 32'hDEAD_BEEF, 1, 0, 0, exp_of(1, 2, 32'h2000_0010, 0, 0));
    chk("st_ready", 32'(REQ_READY), 1);
    idle(1, 0, 0);
    chk("st_htrans", 32'(HTRANS), 2);
    chk("st_hwrite", 32'(HWRITE), 1);
    chk("st_hsize", 32'(HSIZE), 2);
    chk("st_haddr", HADDR, 32'h2000_0010);
    chk("st_hburst", 32'(HBURST), 0);
    chk("st_hprot", 32'(HPROT), 3);
    idle(1, 0, 0);
    chk("st_hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("st_rsp_early", 32'(RSP_VALID), 0);
    idle(1, 0, 0);
    chk("st_rsp_valid", 32'(RSP_VALID), 1);
    chk("st_rsp_err", 32'(RSP_ERR), 0);
    drain("st_drain");

    // Byte load then half store, pipelined
    step(1, 0, 0, 32'h2000_0003, 0, 1, 0, 0, exp_of(0, 0, 32'h2000_0003, 32'hAB00_0000, 0));
    step(1, 1, 1, 32'h0000_0002, 32'h0000_1234, 1, 0, 0, exp_of(1, 1, 32'h2, 0, 0));
    chk("bl_htrans", 32'(HTRANS), 2);
    chk("bl_haddr", HADDR, 32'h2000_0003);
    chk("bl_hsize", 32'(HSIZE), 0);
    idle(1, 0, 32'hAB00_0000);
    chk("hs_haddr", HADDR, 32'h2);
    chk("hs_hsize", 32'(HSIZE), 1);
    chk("hs_hwrite", 32'(HWRITE), 1);
    idle(1, 0, 32'hFFFF_FFFF);
    chk("hs_hwdata", HWDATA, 32'h1234_1234);
    chk("bl_rdata", RSP_RDATA, 32'h0000_00AB);
    drain("bl_drain");

    // Four back-to-back word loads, two wait states on the second
    step(1, 0, 2, 32'h100, 0, 1, 0, 0, exp_of(0, 2, 32'h100, 32'hA0A0_0000, 0));
    chk("b2b_ready0", 32'(REQ_READY), 1);
    step(1, 0, 2, 32'h104, 0, 1, 0, 0, exp_of(0, 2, 32'h104, 32'hA0A0_0001, 0));
    chk("b2b_ready1", 32'(REQ_READY), 1);
    chk("b2b_haddr1", HADDR, 32'h100);
    step(1, 0, 2, 32'h108, 0, 1, 0, 32'hA0A0_0000, exp_of(0, 2, 32'h108, 32'hA0A0_0002, 0));
    chk("b2b_ready2", 32'(REQ_READY), 1);
    chk("b2b_haddr2", HADDR, 32'h104);
    step(1, 0, 2, 32'h10C, 0, 0, 0, 0, exp_of(0, 2, 32'h10C, 32'hA0A0_0003, 0));
    chk("b2b_wait1_ready", 32'(REQ_READY), 0);
    chk("b2b_wait1_htrans", 32'(HTRANS), 2);
    chk("b2b_wait1_haddr", HADDR, 32'h108);
    step(1, 0, 2, 32'h10C, 0, 0, 0, 0, exp_of(0, 2, 32'h10C, 32'hA0A0_0003, 0));
    chk("b2b_wait2_ready", 32'(REQ_READY), 0);
    chk("b2b_wait2_htrans", 32'(HTRANS), 2);
    chk("b2b_wait2_haddr", HADDR, 32'h108);
    step(1, 0, 2, 32'h10C, 0, 1, 0, 32'hA0A0_0001, exp_of(0, 2, 32'h10C, 32'hA0A0_0003, 0));
    chk("b2b_ready5", 32'(REQ_READY), 1);
    chk("b2b_haddr5", HADDR, 32'h108);
    idle(1, 0, 32'hA0A0_0002);
    chk("b2b_haddr6", HADDR, 32'h10C);
    chk("b2b_htrans6", 32'(HTRANS), 2);
    idle(1, 0, 32'hA0A0_0003);
    chk("b2b_htrans7", 32'(HTRANS), 0);
    drain("b2b_drain");

    // Two-cycle ERROR on first of two pipelined loads
    step(1, 0, 2, 32'h200, 0, 1, 0, 0, exp_of(0, 2, 32'h200, 0, 1));
    step(1, 0, 2, 32'h204, 0, 1, 0, 0, exp_of(0, 2, 32'h204, 32'hDB00_0001, 0));
    chk("err_haddr1", HADDR, 32'h200);
    idle(0, 1, 0);
    chk("err_e1_htrans", 32'(HTRANS), 2);
    chk("err_e1_haddr", HADDR, 32'h204);
    chk("err_e1_ready", 32'(REQ_READY), 0);
    idle(1, 1, 0);
    chk("err_e2_htrans", 32'(HTRANS), 0);
    chk("err_e2_ready", 32'(REQ_READY), 0);
    idle(1, 0, 0);
    chk("err_reissue_htrans", 32'(HTRANS), 2);
    chk("err_reissue_haddr", HADDR, 32'h204);
    chk("err_rsp1_err", 32'(RSP_ERR), 1);
    idle(1, 0, 32'hDB00_0001);
    chk("err_post_htrans", 32'(HTRANS), 0);
    idle(1, 0, 0);
    chk("err_rsp2_valid", 32'(RSP_VALID), 1);
    chk("err_rsp2_err", 32'(RSP_ERR), 0);
    drain("err_drain");

    // Misaligned requests interleaved with aligned loads
    step(1, 0, 2, 32'h400, 0, 1, 0, 0, exp_of(0, 2, 32'h400, 32'hDA00_00DA, 0));
    step(1, 0, 1, 32'h401, 0, 1, 0, 0, exp_of(0, 1, 32'h401, 0, 0));
    chk("mis_htrans1", 32'(HTRANS), 2);
    step(1, 0, 2, 32'h3000_0002, 0, 1, 0, 32'hDA00_00DA, exp_of(0, 2, 32'h3000_0002, 0, 0));
    chk("mis_half_idle", 32'(HTRANS), 0);
    step(1, 0, 2, 32'h408, 0, 1, 0, 32'hFFFF_FFFF, exp_of(0, 2, 32'h408, 32'hDC00_0002, 0));
    chk("mis_word_idle", 32'(HTRANS), 0);
    idle(1, 0, 32'hFFFF_FFFF);
    chk("mis_next_htrans", 32'(HTRANS), 2);
    chk("mis_next_haddr", HADDR, 32'h408);
    idle(1, 0, 32'hDC00_0002);
    chk("mis_word_rsp_err", 32'(RSP_ERR), 1);
    chk("mis_word_rsp_rdata", RSP_RDATA, 0);
    drain("mis_drain");

    // Reset during a waited data phase
    step(1, 0, 2, 32'h500, 0, 1, 0, 0, exp_of(0, 2, 32'h500, 32'h5555_5555, 0));
    idle(1, 0, 0);
    chk("rst2_htrans", 32'(HTRANS), 2);
    idle(0, 0, 32'h5555_5555);
    #1;
    HRESET = 1'b1;
    #1;
    sb.delete();
    chk("rst2_htrans_idle", 32'(HTRANS), 0);
    chk("rst2_haddr", HADDR, 0);
    chk("rst2_hwdata", HWDATA, 0);
    chk("rst2_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst2_ready", 32'(REQ_READY), 1);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1, 0, 32'h5555_5555);
      chk("rst2_no_rsp", 32'(RSP_VALID), 0);
      chk("rst2_no_trans", 32'(HTRANS), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
